internal_node_loader: RTL and testbench
=======================================

// Module: internal_node_loader
// PURPOSE
//  Transmit side of the KD-tree internal-node write interface: accepts 11-bit half-words from the host/IO side
//  (bit 11 = half select), assembles 22-bit {median,index} node words, buffers them in a small FIFO and drives
//  sender_enable/sender_data into internal_node_tree, one node per cycle, in node order 0..NUM_NODES-1.
//  Counts nodes sent and flags completion so the top FSM can leave the tree-load phase.
// PARAMETERS
//  INTERNAL_WIDTH  22  node word width; must be even; HALF_WIDTH = INTERNAL_WIDTH/2
//  NUM_NODES       63  nodes per full tree load
//  FIFO_DEPTH      4   assembled-word buffer depth (power of 2, >=2)
//  COUNT_WIDTH     6   width of sent_count; must hold NUM_NODES
// PORTS
//  clk           in   1               single clock; all state on posedge
//  rst           in   1               asynchronous, active-high reset
//  start         in   1               1-cycle pulse: flush and begin a new load (any state)
//  in_valid      in   1               input half-word valid
//  in_ready      out  1               input half-word accepted when in_valid && in_ready
//  in_data       in   HALF_WIDTH+1    [HALF_WIDTH]=0 low half, =1 high half; [HALF_WIDTH-1:0] payload
//  fsm_enable    in   1               top FSM in tree-load phase; same signal the tree gates wen with
//  sender_enable out  1               node word valid this cycle (tree writes when fsm_enable && sender_enable)
//  sender_data   out  INTERNAL_WIDTH  node word = {high half, low half}
//  sent_count    out  COUNT_WIDTH     nodes transmitted since last start
//  busy          out  1               state is STREAM or DRAIN
//  done          out  1               all NUM_NODES sent; held until start
//  error         out  1               sticky protocol-error flag; cleared by start or rst
// BEHAVIOUR
//  Reset (async, rst=1): state IDLE; FIFO empty and storage zeroed; lo_valid=0; accepted/sent counters 0;
//   outputs in_ready=0, sender_enable=0, sender_data=0, sent_count=0, busy=0, done=0, error=0.
//  States: IDLE -start-> STREAM; STREAM -(accepted==NUM_NODES)-> DRAIN; DRAIN -(sent==NUM_NODES)-> DONE;
//   DONE -start-> STREAM. start in STREAM/DRAIN aborts: flush FIFO, clear lo_valid/counters/error, go STREAM.
//   start has priority over every other event in that cycle; data presented with start is not accepted.
//  in_ready = (state==STREAM) && !fifo_full && (accepted<NUM_NODES); combinational from registered state.
//  Assembly: accepted low half -> lo_reg<=payload, lo_valid<=1; if lo_valid already 1, overwrite and set error.
//   Accepted high half with lo_valid=1 -> push {payload,lo_reg}, lo_valid<=0, accepted+=1.
//   Accepted high half with lo_valid=0 -> dropped, error<=1, no push.
//  Send: sender_enable = busy && fsm_enable && !fifo_empty (combinational); sender_data = FIFO head,
//   0 when empty. Each sender_enable cycle pops one word and increments sent_count.
//  Latency: word pushed at edge N is eligible to send in cycle N+1 (min 1 cycle high-half-accept to send).
//  Simultaneous push and pop: both happen; fullness for in_ready is evaluated on pre-pop count.
//  FIFO pointers wrap modulo FIFO_DEPTH; no overflow (in_ready gated) and no underflow (send gated).
//  fsm_enable=0: no sends; FIFO fills; in_ready drops at full; no data is lost.
//  done is 1 in DONE only; sent_count saturates at NUM_NODES; in DONE, in_ready=0 and sender_enable=0.
// TESTING
//  1 start, stream 63 nodes (low=k, high=0x400|k), fsm_enable=1 -> 63 sender_enable pulses,
//    sender_data=(0x400|k)<<11|k in order k=0..62, sent_count=63, done=1, error=0.
//  2 fsm_enable=0, offer 10 nodes -> in_ready=0 after 4 words buffered, sender_enable=0;
//    raise fsm_enable -> 4 back-to-back pulses, then remaining 6 nodes flow, order preserved.
//  3 high half with no low -> error=1, nothing pushed, sent_count unchanged; low 0x005, low 0x006,
//    high 0x001 -> one word 0x001<<11|0x006, error stays 1 until start.
//  4 assert rst asynchronously mid-STREAM after 20 sends -> all outputs 0 before next edge; load after
//    release+start begins at node 0.
//  5 start pulse in DRAIN with 3 words buffered -> FIFO flushed, sent_count=0, busy=1, no stale word sent.
//  6 in DONE, drive in_valid=1 for 5 cycles -> in_ready=0, done stays 1; start -> done=0, in_ready=1.

Source files
------------

// File: rtl/internal_node_loader_if.sv
// Host half-word input and node-word output bundle of the internal-node loader.
// The loader sits on the slave side; the host/tree side uses master.
interface internal_node_loader_if #(
  parameter int INTERNAL_WIDTH = 22
);
  localparam int HALF_WIDTH = INTERNAL_WIDTH / 2;

  logic                      in_valid;
  logic                      in_ready;
  logic [HALF_WIDTH:0]       in_data;
  logic                      sender_enable;
  logic [INTERNAL_WIDTH-1:0] sender_data;

  modport master (
    output in_valid,
    output in_data,
    input  in_ready,
    input  sender_enable,
    input  sender_data
  );

  modport slave (
    input  in_valid,
    input  in_data,
    output in_ready,
    output sender_enable,
    output sender_data
  );
endinterface

// File: rtl/internal_node_loader.sv
// Assembles {high,low} half-words into KD-tree internal-node words, buffers them
// in a small FIFO and streams them to the tree one per cycle while fsm_enable is high.
module internal_node_loader #(
  parameter int INTERNAL_WIDTH = 22,
  parameter int NUM_NODES      = 63,
  parameter int FIFO_DEPTH     = 4,
  parameter int COUNT_WIDTH    = 6
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic                   i_start,
  input  logic                   i_fsm_enable,
  internal_node_loader_if.slave  io_bus,
  output logic [COUNT_WIDTH-1:0] o_sent_count,
  output logic                   o_busy,
  output logic                   o_done,
  output logic                   o_error
);
  localparam int HALF_WIDTH = INTERNAL_WIDTH / 2;
  localparam int PTR_W      = $clog2(FIFO_DEPTH);
  localparam int CNT_W      = PTR_W + 1;
  localparam logic [COUNT_WIDTH-1:0] NODES_C = COUNT_WIDTH'(NUM_NODES);
  localparam logic [CNT_W-1:0]       DEPTH_C = CNT_W'(FIFO_DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_STREAM, S_DRAIN, S_DONE} state_t;

  state_t                    r_state;
  logic [INTERNAL_WIDTH-1:0] r_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]          r_wr_ptr;
  logic [PTR_W-1:0]          r_rd_ptr;
  logic [CNT_W-1:0]          r_count;
  logic [HALF_WIDTH-1:0]     r_lo;
  logic                      r_lo_valid;
  logic [COUNT_WIDTH-1:0]    r_accepted;
  logic [COUNT_WIDTH-1:0]    r_sent;
  logic                      r_error;

  logic                  w_busy;
  logic                  w_empty;
  logic                  w_full;
  logic                  w_in_ready;
  logic                  w_accept;
  logic                  w_is_high;
  logic [HALF_WIDTH-1:0] w_payload;
  logic                  w_push;
  logic                  w_send;

  assign w_busy     = (r_state == S_STREAM) || (r_state == S_DRAIN);
  assign w_empty    = (r_count == '0);
  assign w_full     = (r_count == DEPTH_C);
  // Fullness is the pre-pop count, so a pop in this cycle never opens the input early.
  assign w_in_ready = (r_state == S_STREAM) && !w_full && (r_accepted < NODES_C);
  assign w_accept   = io_bus.in_valid && w_in_ready && !i_start;
  assign w_is_high  = io_bus.in_data[HALF_WIDTH];
  assign w_payload  = io_bus.in_data[HALF_WIDTH-1:0];
  assign w_push     = w_accept && w_is_high && r_lo_valid;
  assign w_send     = w_busy && i_fsm_enable && !w_empty;

  assign io_bus.in_ready      = w_in_ready;
  assign io_bus.sender_enable = w_send;
  assign io_bus.sender_data   = w_empty ? '0 : r_mem[r_rd_ptr];

  assign o_sent_count = r_sent;
  assign o_busy       = w_busy;
  assign o_done       = (r_state == S_DONE);
  assign o_error      = r_error;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state    <= S_IDLE;
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_lo       <= '0;
      r_lo_valid <= 1'b0;
      r_accepted <= '0;
      r_sent     <= '0;
      r_error    <= 1'b0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else if (i_start) begin
      // start wins over every other event: flush and restart the load
      r_state    <= S_STREAM;
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_lo_valid <= 1'b0;
      r_accepted <= '0;
      r_sent     <= '0;
      r_error    <= 1'b0;
    end else begin
      if (w_accept) begin
        if (!w_is_high) begin
          r_lo       <= w_payload;
          r_lo_valid <= 1'b1;
          if (r_lo_valid) begin
            r_error <= 1'b1;
          end
        end else if (r_lo_valid) begin
          r_lo_valid <= 1'b0;
          r_accepted <= r_accepted + 1'b1;
        end else begin
          r_error <= 1'b1;
        end
      end

      if (w_push) begin
        r_mem[r_wr_ptr] <= {w_payload, r_lo};
        r_wr_ptr        <= r_wr_ptr + 1'b1;
      end

      if (w_send) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
        if (r_sent != NODES_C) begin
          r_sent <= r_sent + 1'b1;
        end
      end

      case ({w_push, w_send})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase

      case (r_state)
        S_STREAM: if (r_accepted == NODES_C) r_state <= S_DRAIN;
        S_DRAIN:  if (r_sent == NODES_C)     r_state <= S_DONE;
        default:  r_state <= r_state;
      endcase
    end
  end
endmodule

// File: tb/tb_internal_node_loader.sv
// Directed bench for internal_node_loader: a per-cycle vector table plus
// hand-written sequences for full loads, back-pressure, reset and restart.
module tb_internal_node_loader;
  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic       fsm_enable;
  logic [5:0] sent_count;
  logic       busy;
  logic       done;
  logic       error;

  int n_vec = 0;
  int n_err = 0;
  int n_sends = 0;
  bit mon_on = 1'b0;
  logic [21:0] exp_q[$];

  internal_node_loader_if #(.INTERNAL_WIDTH(22)) bus_if ();

  internal_node_loader #(
    .INTERNAL_WIDTH(22),
    .NUM_NODES(63),
    .FIFO_DEPTH(4),
    .COUNT_WIDTH(6)
  ) dut (
    .i_clk(clk),
    .i_rst(rst),
    .i_start(start),
    .i_fsm_enable(fsm_enable),
    .io_bus(bus_if.slave),
    .o_sent_count(sent_count),
    .o_busy(busy),
    .o_done(done),
    .o_error(error)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        st;
    logic        fe;
    logic        iv;
    logic [11:0] id;
    logic        rdy;
    logic        se;
    logic [21:0] sd;
    logic [5:0]  cnt;
    logic        busy;
    logic        done;
    logic        err;
  } vec_t;

  vec_t tbl[15];

  function automatic vec_t v(input logic st, input logic fe, input logic iv, input logic [11:0] id,
                             input logic rdy, input logic se, input logic [21:0] sd,
                             input logic [5:0] cnt, input logic b, input logic d, input logic e);
    vec_t r;
    r.st = st; r.fe = fe; r.iv = iv; r.id = id;
    r.rdy = rdy; r.se = se; r.sd = sd; r.cnt = cnt; r.busy = b; r.done = d; r.err = e;
    return r;
  endfunction

  function automatic logic [21:0] mk(input int k);
    logic [10:0] lo;
    logic [10:0] hi;
    lo = 11'(k);
    hi = 11'h400 | 11'(k);
    return {hi, lo};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
    n_vec++;
    if (act !== expv) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, expv);
    end
  endtask

  // Sends are checked in order against the expectation queue whenever enabled.
  always @(negedge clk) begin
    if (mon_on && bus_if.sender_enable === 1'b1) begin
      n_sends++;
      if (exp_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL send_unexpected: got 0x%0h expected no send", bus_if.sender_data);
      end else begin
        logic [21:0] e;
        e = exp_q.pop_front();
        check("send_data", 64'(bus_if.sender_data), 64'(e));
        $display("send data=0x%06h expected=0x%06h", bus_if.sender_data, e);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic put_half(input logic [11:0] d);
    int guard;
    guard = 0;
    bus_if.in_valid = 1'b1;
    bus_if.in_data  = d;
    forever begin
      @(negedge clk);
      if (bus_if.in_ready === 1'b1) begin
        tick();
        break;
      end
      tick();
      guard++;
      if (guard > 300) begin
        n_vec++;
        n_err++;
        $display("FAIL put_timeout: got in_ready=0 for 300 cycles expected handshake data=0x%03h", d);
        break;
      end
    end
    bus_if.in_valid = 1'b0;
  endtask

  task automatic put_node(input int k);
    put_half({1'b0, 11'(k)});
    put_half({1'b1, 11'h400 | 11'(k)});
  endtask

  task automatic wait_q_empty(input string name);
    int guard;
    guard = 0;
    while (exp_q.size() != 0 && guard < 40) begin
      tick();
      guard++;
    end
    check(name, 64'(exp_q.size()), 64'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got no finish expected finish before 100000");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    start = 1'b0;
    fsm_enable = 1'b0;
    bus_if.in_valid = 1'b1;
    bus_if.in_data = 12'h005;

    // reset state, with in_valid deliberately asserted
    @(negedge clk);
    check("rst_in_ready", 64'(bus_if.in_ready), 64'd0);
    check("rst_outputs", 64'({bus_if.sender_enable, bus_if.sender_data, sent_count, busy, done, error}), 64'd0);
    tick();
    rst = 1'b0;
    bus_if.in_valid = 1'b0;

    // per-cycle vectors: st fe iv id | rdy se sd cnt busy done err
    tbl[0]  = v(0, 1, 0, 12'h000, 0, 0, 22'h000000, 6'd0, 0, 0, 0);
    tbl[1]  = v(1, 1, 1, 12'h005, 0, 0, 22'h000000, 6'd0, 0, 0, 0);
    tbl[2]  = v(0, 1, 1, 12'h801, 1, 0, 22'h000000, 6'd0, 1, 0, 0);
    tbl[3]  = v(0, 1, 1, 12'h005, 1, 0, 22'h000000, 6'd0, 1, 0, 1);
    tbl[4]  = v(0, 1, 1, 12'h006, 1, 0, 22'h000000, 6'd0, 1, 0, 1);
    tbl[5]  = v(0, 1, 1, 12'h801, 1, 0, 22'h000000, 6'd0, 1, 0, 1);
    tbl[6]  = v(0, 1, 0, 12'h000, 1, 1, 22'h000806, 6'd0, 1, 0, 1);
    tbl[7]  = v(0, 1, 0, 12'h000, 1, 0, 22'h000000, 6'd1, 1, 0, 1);
    tbl[8]  = v(0, 0, 1, 12'h0AA, 1, 0, 22'h000000, 6'd1, 1, 0, 1);
    tbl[9]  = v(0, 0, 1, 12'h955, 1, 0, 22'h000000, 6'd1, 1, 0, 1);
    tbl[10] = v(0, 0, 0, 12'h000, 1, 0, 22'h0AA8AA, 6'd1, 1, 0, 1);
    tbl[11] = v(0, 1, 0, 12'h000, 1, 1, 22'h0AA8AA, 6'd1, 1, 0, 1);
    tbl[12] = v(0, 1, 0, 12'h000, 1, 0, 22'h000000, 6'd2, 1, 0, 1);
    tbl[13] = v(1, 1, 0, 12'h000, 1, 0, 22'h000000, 6'd2, 1, 0, 1);
    tbl[14] = v(0, 1, 0, 12'h000, 1, 0, 22'h000000, 6'd0, 1, 0, 0);

    for (int i = 0; i < 15; i++) begin
      logic [32:0] act;
      logic [32:0] expv;
      start = tbl[i].st;
      fsm_enable = tbl[i].fe;
      bus_if.in_valid = tbl[i].iv;
      bus_if.in_data = tbl[i].id;
      @(negedge clk);
      act  = {bus_if.in_ready, bus_if.sender_enable, bus_if.sender_data, sent_count, busy, done, error};
      expv = {tbl[i].rdy, tbl[i].se, tbl[i].sd, tbl[i].cnt, tbl[i].busy, tbl[i].done, tbl[i].err};
      check($sformatf("vec%0d", i), 64'(act), 64'(expv));
      $display("vec %0d in=0x%03h rdy=%0b se=%0b sd=0x%06h cnt=%0d err=%0b", i, tbl[i].id,
               bus_if.in_ready, bus_if.sender_enable, bus_if.sender_data, sent_count, error);
      tick();
    end
    start = 1'b0;
    bus_if.in_valid = 1'b0;

    // full 63-node load
    $display("full load");
    do_start();
    fsm_enable = 1'b1;
    mon_on = 1'b1;
    n_sends = 0;
    for (int k = 0; k < 63; k++) exp_q.push_back(mk(k));
    for (int k = 0; k < 63; k++) put_node(k);
    for (int g = 0; g < 20 && done !== 1'b1; g++) tick();
    @(negedge clk);
    check("load_done", 64'(done), 64'd1);
    check("load_count", 64'(sent_count), 64'd63);
    check("load_error", 64'(error), 64'd0);
    check("load_pulses", 64'(n_sends), 64'd63);
    check("load_busy", 64'(busy), 64'd0);
    tick();

    // DONE ignores input
    bus_if.in_valid = 1'b1;
    bus_if.in_data = 12'h005;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      check("done_hold", 64'({bus_if.in_ready, bus_if.sender_enable, done}), 64'b001);
      tick();
    end
    bus_if.in_valid = 1'b0;
    do_start();
    @(negedge clk);
    check("restart", 64'({bus_if.in_ready, done, busy}), 64'b101);
    tick();

    // back-pressure with fsm_enable low
    $display("back-pressure");
    do_start();
    fsm_enable = 1'b0;
    for (int k = 0; k < 10; k++) exp_q.push_back(mk(k));
    for (int k = 0; k < 4; k++) put_node(k);
    bus_if.in_valid = 1'b1;
    bus_if.in_data = {1'b0, 11'd4};
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check("bp_full", 64'({bus_if.in_ready, bus_if.sender_enable}), 64'b00);
      tick();
    end
    fsm_enable = 1'b1;
    @(negedge clk);
    check("bp_first", 64'({bus_if.in_ready, bus_if.sender_enable}), 64'b01);
    tick();
    @(negedge clk);
    check("bp_second", 64'({bus_if.in_ready, bus_if.sender_enable}), 64'b11);
    tick();
    bus_if.in_valid = 1'b0;
    put_half({1'b1, 11'h404});
    for (int k = 5; k < 10; k++) put_node(k);
    wait_q_empty("bp_drain");
    @(negedge clk);
    check("bp_count", 64'(sent_count), 64'd10);
    check("bp_error", 64'(error), 64'd0);
    tick();

    // restart in DRAIN with 3 words buffered
    $display("drain abort");
    do_start();
    for (int k = 0; k < 60; k++) exp_q.push_back(mk(k));
    for (int k = 0; k < 60; k++) put_node(k);
    wait_q_empty("dr_sent60");
    fsm_enable = 1'b0;
    for (int k = 60; k < 63; k++) put_node(k);
    tick();
    @(negedge clk);
    check("dr_state", 64'({busy, done, bus_if.sender_enable, bus_if.in_ready}), 64'b1000);
    check("dr_count", 64'(sent_count), 64'd60);
    check("dr_head", 64'(bus_if.sender_data), 64'(mk(60)));
    tick();
    do_start();
    @(negedge clk);
    check("dr_flush", 64'({busy, bus_if.sender_enable, bus_if.sender_data, sent_count}),
          64'({1'b1, 1'b0, 22'd0, 6'd0}));
    tick();
    fsm_enable = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check("dr_no_stale", 64'(bus_if.sender_enable), 64'd0);
      tick();
    end

    // async reset mid-stream
    $display("async reset");
    do_start();
    for (int k = 0; k < 63; k++) begin
      exp_q.push_back(mk(k));
      put_node(k);
      if (sent_count >= 6'd20) break;
    end
    mon_on = 1'b0;
    #2;
    rst = 1'b1;
    bus_if.in_valid = 1'b0;
    #1;
    check("ar_in_ready", 64'(bus_if.in_ready), 64'd0);
    check("ar_outputs", 64'({bus_if.sender_enable, bus_if.sender_data, sent_count, busy, done, error}), 64'd0);
    exp_q.delete();
    tick();
    rst = 1'b0;
    mon_on = 1'b1;
    do_start();
    exp_q.push_back(mk(0));
    exp_q.push_back(mk(1));
    put_node(0);
    put_node(1);
    wait_q_empty("ar_reload");
    @(negedge clk);
    check("ar_count", 64'(sent_count), 64'd2);
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
